// File: rtl/addsub_sm_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_sm_seq_pkg
//  Description : Shared state encoding and operation codes for the multi-cycle
//                sign-magnitude adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_sm_seq_pkg;

    // Sequencer states: operand conversion, chunked addition, result fix-up
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ADD  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    localparam logic C_OP_ADD = 1'b0;
    localparam logic C_OP_SUB = 1'b1;

endpackage : addsub_sm_seq_pkg
`default_nettype wire

// File: rtl/addsub_sm_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_sm_seq_chunk_adder
//  Description : Combinational CHUNK-bit ripple-carry adder. Also exposes the
//                carry into its top bit so the caller can detect signed
//                overflow on the final chunk.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_sm_seq_chunk_adder
    import addsub_sm_seq_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic             cin,
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    // Full-adder cell per bit, carry rippling upward
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign cout  = w_c[CHUNK];
    assign c_msb = w_c[CHUNK-1];

endmodule : addsub_sm_seq_chunk_adder
`default_nettype wire

// File: rtl/addsub_sm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_sm_seq
//  Description : Multi-cycle sign-magnitude adder/subtractor. Operands are
//                converted to two's complement, summed CHUNK bits per cycle,
//                then converted back with saturation on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_sm_seq
    import addsub_sm_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N) + 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("addsub_sm_seq: WIDTH must be a multiple of CHUNK");
    end

    // Sign-magnitude to two's complement; -0 maps to 0 because ~0+1 wraps
    function automatic logic [WIDTH-1:0] to_tc(input logic [WIDTH-1:0] sm);
        logic [WIDTH-1:0] m;
        m = {1'b0, sm[WIDTH-2:0]};
        return sm[WIDTH-1] ? (~m + WIDTH'(1)) : m;
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             sa_q, sa_d;
    logic             carry_q, carry_d;
    logic             cin_msb_q, cin_msb_d;
    logic             cout_msb_q, cout_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] w_b_sm;
    logic [WIDTH-1:0] w_ta_tc;
    logic [WIDTH-1:0] w_tb_tc;
    logic [CHUNK-1:0] w_s;
    logic             w_cout;
    logic             w_c_msb;
    logic             w_ovf_tc;
    logic             w_sign;
    logic [WIDTH-2:0] w_mag;
    logic             w_min;
    logic             w_ovf;

    // Subtraction is addition with B's sign flipped
    assign w_b_sm  = {opb_q[WIDTH-1] ^ (op_q == C_OP_SUB), opb_q[WIDTH-2:0]};
    assign w_ta_tc = to_tc(opa_q);
    assign w_tb_tc = to_tc(w_b_sm);

    addsub_sm_seq_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .cin   (carry_q),
        .x     (opa_q[CHUNK-1:0]),
        .y     (opb_q[CHUNK-1:0]),
        .s     (w_s),
        .cout  (w_cout),
        .c_msb (w_c_msb)
    );

    // Conversion back to sign-magnitude; the most negative sum has no
    // magnitude representation and is treated as overflow too
    assign w_ovf_tc = cin_msb_q ^ cout_msb_q;
    assign w_sign   = w_ovf_tc ? sa_q : sum_q[WIDTH-1];
    assign w_mag    = w_sign ? (~sum_q[WIDTH-2:0] + (WIDTH-1)'(1)) : sum_q[WIDTH-2:0];
    assign w_min    = !w_ovf_tc && (sum_q == {1'b1, {(WIDTH-1){1'b0}}});
    assign w_ovf    = w_ovf_tc | w_min;

    // Next-state and datapath: operands and sum shift right one chunk per ADD cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        sum_d      = sum_q;
        sa_d       = sa_q;
        carry_d    = carry_q;
        cin_msb_d  = cin_msb_q;
        cout_msb_d = cout_msb_q;
        result_d   = result_q;
        neg_d      = neg_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    op_d    = op;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                opa_d   = w_ta_tc;
                opb_d   = w_tb_tc;
                sa_d    = w_ta_tc[WIDTH-1];
                carry_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                sum_d   = (sum_q >> CHUNK) | (WIDTH'(w_s) << (WIDTH - CHUNK));
                carry_d = w_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cin_msb_d  = w_c_msb;
                    cout_msb_d = w_cout;
                    cnt_d      = '0;
                    state_d    = ST_FIX;
                end
            end
            ST_FIX: begin
                done_d  = 1'b1;
                ovf_d   = w_ovf;
                neg_d   = w_sign;
                zero_d  = 1'b0;
                state_d = ST_IDLE;
                if (w_ovf) begin
                    result_d = {w_sign, {(WIDTH-1){1'b1}}};
                end else if (w_mag == '0) begin
                    result_d = '0;
                    neg_d    = 1'b0;
                    zero_d   = 1'b1;
                end else begin
                    result_d = {w_sign, w_mag};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            sum_q      <= '0;
            sa_q       <= 1'b0;
            carry_q    <= 1'b0;
            cin_msb_q  <= 1'b0;
            cout_msb_q <= 1'b0;
            result_q   <= '0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            sum_q      <= sum_d;
            sa_q       <= sa_d;
            carry_q    <= carry_d;
            cin_msb_q  <= cin_msb_d;
            cout_msb_q <= cout_msb_d;
            result_q   <= result_d;
            neg_q      <= neg_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign neg    = neg_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule : addsub_sm_seq
`default_nettype wire

// File: tb/tb_addsub_sm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_sm_seq
//  Description : Self-checking bench for addsub_sm_seq (WIDTH=8, CHUNK=4).
//                An arithmetic reference model predicts every output on every
//                cycle; directed cases pin literal results and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_sm_seq;

    localparam int W   = 8;
    localparam int C   = 4;
    localparam int N   = W / C;
    localparam int LAT = N + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] ia = '0;
    logic [W-1:0] ib = '0;
    logic         busy, done, neg, zero, ovf;
    logic [W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    addsub_sm_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (ia),
        .b      (ib),
        .busy   (busy),
        .done   (done),
        .result (result),
        .neg    (neg),
        .zero   (zero),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: exact integer sum, then sign-magnitude encoding
    function automatic void model_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic o, output logic [W-1:0] r,
                                       output logic n, output logic z, output logic v);
        int va, vb, s, m;
        va = x[W-1] ? -int'(x[W-2:0]) : int'(x[W-2:0]);
        vb = (y[W-1] ^ o) ? -int'(y[W-2:0]) : int'(y[W-2:0]);
        s  = va + vb;
        m  = (s < 0) ? -s : s;
        v  = (m > (1 << (W-1)) - 1);
        n  = (s < 0);
        z  = !v && (s == 0);
        if (v)           r = {n, {(W-1){1'b1}}};
        else if (s == 0) r = '0;
        else             r = {n, m[W-2:0]};
    endfunction

    // Cycle-level expectation: busy for N+2 cycles after acceptance, then a done pulse
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         m_neg = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
    logic         p_neg = 1'b0, p_zero = 1'b0, p_ovf = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_left = 0;
            m_res  = '0;
            m_neg  = 1'b0;
            m_zero = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left = N + 2;
                model_calc(ia, ib, op, p_res, p_neg, p_zero, p_ovf);
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res  = p_res;
                m_neg  = p_neg;
                m_zero = p_zero;
                m_ovf  = p_ovf;
            end
        end
    end

    // Compare every output against the model on every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if ({busy, done, result, neg, zero, ovf} !==
                {(m_left != 0), m_done, m_res, m_neg, m_zero, m_ovf}) begin
                n_fail++;
                $display("FAIL model t=%0t: busy/done/result/neg/zero/ovf got %b %b %h %b %b %b expected %b %b %h %b %b %b",
                         $time, busy, done, result, neg, zero, ovf,
                         (m_left != 0), m_done, m_res, m_neg, m_zero, m_ovf);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; returns the cycle it arrived
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                          output int lat);
        lat   = 0;
        start = 1'b1;
        ia    = x;
        ib    = y;
        op    = o;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && lat == 0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic o, input logic [W-1:0] er, input logic en,
                            input logic ez, input logic eo);
        int lat;
        run_op(x, y, o, lat);
        chk({nm, " latency"}, lat, LAT);
        chk({nm, " result"}, result, er);
        chk({nm, " neg"}, neg, en);
        chk({nm, " zero"}, zero, ez);
        chk({nm, " ovf"}, ovf, eo);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return {1'($urandom_range(0, 1)), 7'h7F};
            3:       return {1'($urandom_range(0, 1)), 7'h40};
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset result", result, 8'h00);
        chk("reset flags", {busy, done, neg, zero, ovf}, 5'b0);
        chk_en = 1'b1;

        directed("add_pos_neg", 8'h05, 8'h83, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        directed("sub_neg",     8'h03, 8'h05, 1'b1, 8'h82, 1'b1, 1'b0, 1'b0);
        directed("ovf_pos",     8'h64, 8'h32, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        directed("ovf_min",     8'hC0, 8'hC0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
        directed("neg_zero",    8'h80, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        // Start issued in the done cycle of the previous operation
        directed("back_to_back", 8'h7F, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);

        // New start while busy is ignored
        start = 1'b1; ia = 8'h05; ib = 8'h83; op = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin ia = 8'h7F; ib = 8'h7F; op = 1'b0; end
            if (done && lat == 0) begin lat = k; break; end
        end
        chk("busy_ignore latency", lat, LAT);
        chk("busy_ignore result", result, 8'h02);

        // Reset in the middle of the addition
        start = 1'b1; ia = 8'h11; ib = 8'h22; op = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_rst busy", busy, 1'b0);
        chk("mid_rst result", result, 8'h00);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) lat = 1;
            @(negedge clk);
        end
        chk("mid_rst no done", lat, 0);

        // Randomized traffic, including starts while busy and sporadic resets
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 1'($urandom_range(0, 1));
            ia    = pick();
            ib    = pick();
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_addsub_sm_seq
`default_nettype wire
